vx_gbar_unit: RTL and testbench

//  Global-barrier responder: terminates the gbar request bus driven by the socket-level gbar arbiters.

---
 rtl/vx_gbar_unit_pkg.sv | 22 ++
 rtl/vx_gbar_unit_popcount.sv | 19 +
 rtl/vx_gbar_unit.sv | 128 ++++++++++++
 tb/tb_vx_gbar_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vx_gbar_unit_pkg.sv
// Shared definitions for the cluster-level global-barrier responder.
// Provides the default barrier/core counts, the derived bus field widths and
// the packed request layout carried on the gbar request bus.
package vx_gbar_unit_pkg;

    // $clog2 that never returns 0, so a single-entry field still has one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GBAR_NUM_BARRIERS = 4;
    localparam int GBAR_NUM_CORES    = 4;
    localparam int GBAR_BAR_W        = clog2_min1(GBAR_NUM_BARRIERS);
    localparam int GBAR_CORE_W       = clog2_min1(GBAR_NUM_CORES);

    typedef struct packed {
        logic [GBAR_BAR_W-1:0]  id;
        logic [GBAR_CORE_W-1:0] size_m1;
        logic [GBAR_CORE_W-1:0] core_id;
    } gbar_req_t;

endpackage

// File: rtl/vx_gbar_unit_popcount.sv
// Population count of a core arrival mask.
//   mask   in  N      arrival mask
//   count  out CNT_W  number of set bits
module vx_gbar_popcount #(
    parameter int N     = 4,
    parameter int CNT_W = 3
) (
    input  logic [N-1:0]     mask,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CNT_W'(mask[i]);
        end
    end

endmodule

// File: rtl/vx_gbar_unit.sv
// Global-barrier responder. Collects per-barrier core arrivals from the
// socket gbar arbiters and broadcasts a one-cycle release once every
// participating core of a barrier has arrived.
//   clk          in   1       clock
//   reset        in   1       synchronous active-high reset
//   req_valid    in   1       barrier arrival request
//   req_id       in   BAR_W   barrier index
//   req_size_m1  in   CORE_W  participating cores minus one
//   req_core_id  in   CORE_W  arriving core
//   req_ready    out  1       request accepted when req_valid && req_ready
//   rsp_valid    out  1       one-cycle release broadcast
//   rsp_id       out  BAR_W   released barrier index
//   busy         out  1       some barrier has a partial arrival mask
module vx_gbar_unit
    import vx_gbar_unit_pkg::*;
#(
    parameter int NUM_BARRIERS = GBAR_NUM_BARRIERS,
    parameter int NUM_CORES    = GBAR_NUM_CORES,
    localparam int BAR_W       = clog2_min1(NUM_BARRIERS),
    localparam int CORE_W      = clog2_min1(NUM_CORES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [BAR_W-1:0]  req_id,
    input  logic [CORE_W-1:0] req_size_m1,
    input  logic [CORE_W-1:0] req_core_id,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [BAR_W-1:0]  rsp_id,
    output logic              busy
);

    logic [NUM_CORES-1:0] mask_r [NUM_BARRIERS];
    logic [CORE_W-1:0]    size_r [NUM_BARRIERS];
    logic                 ready_r;

    logic                 id_ok;
    logic                 core_ok;
    logic                 accept_p0;
    logic [NUM_CORES-1:0] cur_mask_p0;
    logic [NUM_CORES-1:0] core_bit_p0;
    logic [NUM_CORES-1:0] new_mask_p0;
    logic                 dup_p0;
    logic                 active_p0;
    logic [CORE_W-1:0]    eff_size_p0;
    logic [CORE_W:0]      new_cnt_p0;
    logic [CORE_W:0]      target_p0;
    logic                 release_p0;

    logic                 rsp_valid_p1;
    logic [BAR_W-1:0]     rsp_id_p1;

    // ---- stage p0: decode the arrival against the stored barrier state ----
    // Out-of-range ids/cores are accepted (ready stays high) but never
    // touch state; only possible for non power-of-two configurations.
    always_comb begin
        id_ok       = int'(req_id) < NUM_BARRIERS;
        core_ok     = int'(req_core_id) < NUM_CORES;
        accept_p0   = req_valid && ready_r && id_ok && core_ok;
        cur_mask_p0 = id_ok ? mask_r[req_id] : '0;
        core_bit_p0 = core_ok ? (NUM_CORES'(1) << req_core_id) : '0;
        new_mask_p0 = cur_mask_p0 | core_bit_p0;
        dup_p0      = |(cur_mask_p0 & core_bit_p0);
        active_p0   = |cur_mask_p0;
        // The first arrival defines the group size; later sizes are ignored.
        eff_size_p0 = (active_p0 && id_ok) ? size_r[req_id] : req_size_m1;
        target_p0   = {1'b0, eff_size_p0} + (CORE_W + 1)'(1);
        // A repeated arrival can never complete a barrier on its own.
        release_p0  = accept_p0 && !dup_p0 && (new_cnt_p0 == target_p0);
    end

    vx_gbar_popcount #(
        .N     (NUM_CORES),
        .CNT_W (CORE_W + 1)
    ) u_popcount (
        .mask  (new_mask_p0),
        .count (new_cnt_p0)
    );

    // ---- stage p1: state update and registered release ----
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r      <= 1'b0;
            rsp_valid_p1 <= 1'b0;
            rsp_id_p1    <= '0;
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                mask_r[b] <= '0;
                size_r[b] <= '0;
            end
        end else begin
            ready_r      <= 1'b1;
            rsp_valid_p1 <= release_p0;
            if (release_p0) begin
                rsp_id_p1 <= req_id;
            end
            if (accept_p0) begin
                if (!active_p0) begin
                    size_r[req_id] <= req_size_m1;
                end
                mask_r[req_id] <= release_p0 ? '0 : new_mask_p0;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            busy = busy | (|mask_r[b]);
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_p1;
    assign rsp_id    = rsp_id_p1;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && req_valid && ready_r) begin
            assert (id_ok)
                else $error("gbar request with out-of-range barrier id %0d", req_id);
            assert (core_ok)
                else $error("gbar request with out-of-range core id %0d", req_core_id);
        end
    end
`endif

endmodule

// File: tb/tb_vx_gbar_unit.sv
module tb_vx_gbar_unit;

    localparam int NB     = 4;
    localparam int NC     = 4;
    localparam int BAR_W  = 2;
    localparam int CORE_W = 2;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic [BAR_W-1:0]  req_id;
    logic [CORE_W-1:0] req_size_m1;
    logic [CORE_W-1:0] req_core_id;
    logic              req_ready;
    logic              rsp_valid;
    logic [BAR_W-1:0]  rsp_id;
    logic              busy;

    int n_vec;
    int n_err;

    // Reference model: per barrier, which cores have arrived, how many, and
    // how many are needed (fixed by the first arrival of a round).
    bit seen [NB][NC];
    int arrived [NB];
    int needed [NB];

    vx_gbar_unit #(
        .NUM_BARRIERS (NB),
        .NUM_CORES    (NC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_id      (req_id),
        .req_size_m1 (req_size_m1),
        .req_core_id (req_core_id),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_busy();
        for (int b = 0; b < NB; b++) begin
            if (arrived[b] != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_clear();
        for (int b = 0; b < NB; b++) begin
            arrived[b] = 0;
            needed[b]  = 0;
            for (int c = 0; c < NC; c++) seen[b][c] = 1'b0;
        end
    endfunction

    // Apply one arrival to the model; returns 1 when it completes the barrier.
    function automatic bit model_arrive(input int id, input int sz, input int core);
        if (arrived[id] == 0) needed[id] = sz + 1;
        if (seen[id][core]) return 1'b0;
        seen[id][core] = 1'b1;
        arrived[id]++;
        if (arrived[id] == needed[id]) begin
            arrived[id] = 0;
            for (int c = 0; c < NC; c++) seen[id][c] = 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: drive (optionally) a request, then check the outputs of the
    // cycle after the edge that sampled it.
    task automatic cyc(input bit v, input int id, input int sz, input int core);
        bit exp_v;
        req_valid   = v;
        req_id      = BAR_W'(id);
        req_size_m1 = CORE_W'(sz);
        req_core_id = CORE_W'(core);
        @(posedge clk);
        exp_v = v ? model_arrive(id, sz, core) : 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("rsp_valid", int'(rsp_valid), int'(exp_v));
        if (exp_v) check("rsp_id", int'(rsp_id), id);
        check("busy", int'(busy), int'(model_busy()));
        check("req_ready", int'(req_ready), 1);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", int'(req_ready), 0);
        check("rsp_valid_in_reset", int'(rsp_valid), 0);
        check("busy_in_reset", int'(busy), 0);
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", int'(req_ready), 1);
        check("rsp_valid_after_reset", int'(rsp_valid), 0);
        check("rsp_id_after_reset", int'(rsp_id), 0);
        check("busy_after_reset", int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_id      = '0;
        req_size_m1 = '0;
        req_core_id = '0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Four cores on barrier 1, one per cycle.
        for (int c = 0; c < 4; c++) cyc(1'b1, 1, 3, c);
        cyc(1'b0, 0, 0, 0);

        // Duplicate arrival on barrier 0, then the completing core.
        cyc(1'b1, 0, 1, 2);
        cyc(1'b1, 0, 1, 2);
        cyc(1'b1, 0, 1, 0);

        // Interleaved barriers 0 and 2.
        cyc(1'b1, 0, 1, 1);
        cyc(1'b1, 2, 2, 0);
        cyc(1'b1, 2, 2, 3);
        cyc(1'b1, 0, 1, 3);
        cyc(1'b1, 2, 2, 1);

        // Single-core barrier, back-to-back releases.
        cyc(1'b1, 3, 0, 3);
        cyc(1'b1, 3, 0, 3);
        cyc(1'b0, 0, 0, 0);

        // Second arrival carries a different size; first size is honoured.
        cyc(1'b1, 0, 1, 0);
        cyc(1'b1, 0, 3, 2);
        cyc(1'b0, 0, 0, 0);

        // Reset with a partial barrier 0 and a release in flight.
        cyc(1'b1, 0, 3, 0);
        cyc(1'b1, 0, 3, 1);
        req_valid   = 1'b1;
        req_id      = 2'd3;
        req_size_m1 = 2'd0;
        req_core_id = 2'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("rsp_before_reset", int'(rsp_valid), 1);
        check("rsp_id_before_reset", int'(rsp_id), 3);
        @(posedge clk);
        @(negedge clk);
        check("rsp_cleared_by_reset", int'(rsp_valid), 0);
        check("busy_cleared_by_reset", int'(busy), 0);
        check("ready_low_in_reset", int'(req_ready), 0);
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        check("ready_after_midreset", int'(req_ready), 1);
        check("no_release_after_reset", int'(rsp_valid), 0);
        cyc(1'b1, 0, 1, 1);
        cyc(1'b1, 0, 1, 3);
        cyc(1'b0, 0, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0,
                int'($urandom_range(0, NB - 1)),
                int'($urandom_range(0, NC - 1)),
                int'($urandom_range(0, NC - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
